match_frame_feeder: RTL and testbench

// Producer side of the template-match interface. Waits for a rising trigger crossing on the ADC stream,

---
 rtl/match_frame_feeder_pkg.sv | 16 +
 rtl/match_frame_feeder_if.sv | 23 ++
 rtl/match_frame_feeder_frame_buf_ram.sv | 24 ++
 rtl/match_frame_feeder.sv | 138 +++++++++++++
 tb/tb_match_frame_feeder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/match_frame_feeder_pkg.sv
// Shared types and constants for the frame feeder and the template matcher.
package match_pkg;

   typedef enum logic [2:0] {IDLE, ARM, CAPTURE, REPLAY, DONE} state_t;

   typedef enum logic [1:0] {TRI = 2'd0, SQR = 2'd1, SIN = 2'd2} wave_t;

   localparam int DOFFSET = 128;

   function automatic logic [7:0] sat_u8(input logic signed [15:0] v);
      if (v < 16'sd0)   return 8'd0;
      if (v > 16'sd255) return 8'hFF;
      return v[7:0];
   endfunction

endpackage

// File: rtl/match_frame_feeder_if.sv
// ADC-in / matcher-out bundle of the frame feeder; master is the feeder side.
interface match_frame_feeder_if #(parameter int AW = 8);
   logic          start;
   logic          adc_valid;
   logic [7:0]    adc_data;
   logic          busy;
   logic          forced;
   logic [AW-1:0] tmpl_addr;
   logic          wave_valid;
   logic [7:0]    wave_in;
   logic [7:0]    dwave_in;
   logic          frame_done;

   modport master (
      input  start, adc_valid, adc_data,
      output busy, forced, tmpl_addr, wave_valid, wave_in, dwave_in, frame_done
   );

   modport slave (
      output start, adc_valid, adc_data,
      input  busy, forced, tmpl_addr, wave_valid, wave_in, dwave_in, frame_done
   );
endinterface

// File: rtl/match_frame_feeder_frame_buf_ram.sv
// Simple dual-port frame buffer, one write port and one synchronous read port.
module frame_buf_ram #(
   parameter int W     = 8,
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   // No reset on the read register so this maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/match_frame_feeder.sv
// Triggered frame capture and replay with derivative stream for the template matcher.
module match_frame_feeder
   import match_pkg::*;
#(
   parameter int FRAME_LEN    = 256,
   parameter int AW           = 8,
   parameter int TRIG_LEVEL   = 128,
   parameter int TRIG_TIMEOUT = 4096,
   parameter int DSHIFT       = 2
) (
   input  logic clk,
   input  logic rst,
   match_frame_feeder_if.master bus
);

   localparam int TW = $clog2(TRIG_TIMEOUT) + 1;
   localparam int DW = 9 + DSHIFT;

   state_t         state;
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           rd_act;
   logic [1:0]     vld_pipe;
   logic [7:0]     prev;
   logic           prev_ok;
   logic [TW-1:0]  to_cnt;
   logic           trig;
   logic           tmo;
   logic           we;
   logic [AW-1:0]  waddr;
   logic [7:0]     rd_data;

   logic signed [8:0]    diff9;
   logic signed [DW-1:0] diff;
   logic signed [15:0]   dsum;

   assign trig  = prev_ok && (prev < 8'(TRIG_LEVEL)) && (bus.adc_data >= 8'(TRIG_LEVEL));
   assign tmo   = (to_cnt == TW'(TRIG_TIMEOUT - 1));
   assign we    = bus.adc_valid && ((state == ARM && (trig || tmo)) || state == CAPTURE);
   assign waddr = (state == ARM) ? '0 : wr_ptr;

   frame_buf_ram #(.W(8), .DEPTH(FRAME_LEN), .AW(AW)) u_buf (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (bus.adc_data),
      .re    (rd_act),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         bus.busy       <= 1'b0;
         bus.forced     <= 1'b0;
         bus.frame_done <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         rd_act         <= 1'b0;
         prev           <= '0;
         prev_ok        <= 1'b0;
         to_cnt         <= '0;
      end else begin
         bus.frame_done <= 1'b0;
         unique case (state)
            IDLE: if (bus.start) begin
               state      <= ARM;
               bus.busy   <= 1'b1;
               bus.forced <= 1'b0;
               to_cnt     <= '0;
               prev_ok    <= 1'b0;
            end
            ARM: if (bus.adc_valid) begin
               prev    <= bus.adc_data;
               prev_ok <= 1'b1;
               to_cnt  <= to_cnt + TW'(1);
               // A coincident trigger wins, so forced only reflects a pure timeout.
               if (trig || tmo) begin
                  state      <= CAPTURE;
                  wr_ptr     <= AW'(1);
                  bus.forced <= !trig;
               end
            end
            CAPTURE: if (bus.adc_valid) begin
               wr_ptr <= wr_ptr + AW'(1);
               if (wr_ptr == AW'(FRAME_LEN - 1)) begin
                  state  <= REPLAY;
                  rd_act <= 1'b1;
                  rd_ptr <= '0;
               end
            end
            REPLAY: begin
               if (rd_act) begin
                  rd_ptr <= rd_ptr + AW'(1);
                  if (rd_ptr == AW'(FRAME_LEN - 1)) rd_act <= 1'b0;
               end
               // Leave once the final wave_valid cycle is on the outputs.
               if (vld_pipe[1] && !vld_pipe[0]) begin
                  state          <= DONE;
                  bus.frame_done <= 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign diff9 = $signed({1'b0, rd_data}) - $signed({1'b0, bus.wave_in});
   assign diff  = DW'(diff9) <<< DSHIFT;
   assign dsum  = 16'(diff) + 16'(DOFFSET);

   // vld_pipe[0] marks RAM output valid, vld_pipe[1] marks the output registers valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe      <= '0;
         bus.tmpl_addr <= '0;
         bus.wave_in   <= '0;
         bus.dwave_in  <= 8'(DOFFSET);
      end else begin
         vld_pipe      <= {vld_pipe[0], rd_act};
         bus.tmpl_addr <= rd_act ? rd_ptr : '0;
         if (vld_pipe[0]) begin
            bus.wave_in  <= rd_data;
            bus.dwave_in <= vld_pipe[1] ? sat_u8(dsum) : 8'(DOFFSET);
         end else begin
            bus.dwave_in <= 8'(DOFFSET);
         end
      end
   end

   assign bus.wave_valid = vld_pipe[1];

endmodule

// File: tb/tb_match_frame_feeder.sv
// Directed bench for match_frame_feeder: ramp, timeout, square, sparse ADC and mid-frame reset.
module tb_match_frame_feeder;

   logic clk = 1'b0;
   logic rst = 1'b1;

   match_frame_feeder_if #(.AW(8)) bus ();

   match_frame_feeder #(
      .FRAME_LEN(256), .AW(8), .TRIG_LEVEL(128), .TRIG_TIMEOUT(4096), .DSHIFT(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] w_log [0:8191];
   logic [7:0] d_log [0:8191];
   int   vcnt = 0, fidx = 0, runs = 0, done_total = 0, done_err = 0, addr_err = 0;
   logic       m_pv = 1'b0;
   logic [7:0] m_pa = 8'd0;

   // Stream monitor: logs replayed samples and flags misalignment / stray frame_done.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.wave_valid) begin
            if (!m_pv) begin
               fidx = 0;
               runs++;
            end
            if (m_pa !== 8'(fidx)) addr_err++;
            w_log[vcnt & 8191] = bus.wave_in;
            d_log[vcnt & 8191] = bus.dwave_in;
            vcnt++;
            fidx++;
         end
         if (bus.frame_done) begin
            done_total++;
            if (!(m_pv && !bus.wave_valid)) done_err++;
         end
         m_pv = bus.wave_valid;
         m_pa = bus.tmpl_addr;
      end
   end

   function automatic logic [7:0] ramp_w(input int k);
      return 8'((128 + k) % 256);
   endfunction
   function automatic logic [7:0] ramp_d(input int k);
      if (k == 0)   return 8'd128;
      if (k == 128) return 8'd0;
      return 8'd132;
   endfunction
   function automatic logic [7:0] sq_w(input int k);
      return (k % 16 < 8) ? 8'd255 : 8'd0;
   endfunction
   function automatic logic [7:0] sq_d(input int k);
      if (k == 0)      return 8'd128;
      if (k % 16 == 8) return 8'd0;
      if (k % 16 == 0) return 8'd255;
      return 8'd128;
   endfunction

   // Modes: 0 ramp, 1 constant 50, 2 square 0/255, 3 ramp valid 1-in-3.
   task automatic drive_adc(input int mode, input int i, inout int smp);
      case (mode)
         0: begin bus.adc_valid = 1'b1; bus.adc_data = 8'((i + 10) % 256); end
         1: begin bus.adc_valid = 1'b1; bus.adc_data = 8'd50; end
         2: begin bus.adc_valid = 1'b1; bus.adc_data = ((i / 8) % 2 == 1) ? 8'd255 : 8'd0; end
         default: begin
            if (i % 3 == 0) begin
               bus.adc_valid = 1'b1;
               bus.adc_data  = 8'(smp % 256);
               smp++;
            end else begin
               bus.adc_valid = 1'b0;
               bus.adc_data  = 8'hAA;
            end
         end
      endcase
   endtask

   task automatic run_frame(input int mode, input bit poke, input int budget, output bit got);
      int d0;
      int smp;
      d0  = done_total;
      smp = 0;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(posedge clk); #1;
         if (done_total != d0) begin
            got           = 1'b1;
            bus.start     = 1'b0;
            bus.adc_valid = 1'b0;
         end else begin
            bus.start = (i == 0) || (poke && bus.busy && ((i % 97 == 50) || bus.frame_done));
            drive_adc(mode, i, smp);
         end
      end
   endtask

   task automatic test_reset;
      bus.start = 1'b0; bus.adc_valid = 1'b0; bus.adc_data = 8'd0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", bus.busy); end
      n_cmp++; if (bus.forced !== 1'b0) begin n_bad++; $display("FAIL rst_forced got %b want 0", bus.forced); end
      n_cmp++; if (bus.tmpl_addr !== 8'd0) begin n_bad++; $display("FAIL rst_addr got %0d want 0", bus.tmpl_addr); end
      n_cmp++; if (bus.wave_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", bus.wave_valid); end
      n_cmp++; if (bus.wave_in !== 8'd0) begin n_bad++; $display("FAIL rst_wave got %0d want 0", bus.wave_in); end
      n_cmp++; if (bus.dwave_in !== 8'd128) begin n_bad++; $display("FAIL rst_dwave got %0d want 128", bus.dwave_in); end
      n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", bus.frame_done); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_ramp;
      int b, r0, d0, a0, e0, errs;
      bit got;
      b = vcnt; r0 = runs; d0 = done_total; a0 = addr_err; e0 = done_err; errs = 0;
      run_frame(0, 1'b1, 2000, got);
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL ramp_timeout got %b want 1", got); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ramp_start_in_done got busy=%b want 0", bus.busy); end
      @(posedge clk); #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ramp_idle got busy=%b want 0", bus.busy); end
      n_cmp++; if (vcnt - b !== 256) begin n_bad++; $display("FAIL ramp_len got %0d want 256", vcnt - b); end
      n_cmp++; if (runs - r0 !== 1) begin n_bad++; $display("FAIL ramp_runs got %0d want 1", runs - r0); end
      n_cmp++; if (done_total - d0 !== 1) begin n_bad++; $display("FAIL ramp_done_cnt got %0d want 1", done_total - d0); end
      n_cmp++; if (done_err - e0 !== 0) begin n_bad++; $display("FAIL ramp_done_pos got %0d want 0", done_err - e0); end
      n_cmp++; if (addr_err - a0 !== 0) begin n_bad++; $display("FAIL ramp_align got %0d want 0", addr_err - a0); end
      n_cmp++; if (bus.forced !== 1'b0) begin n_bad++; $display("FAIL ramp_forced got %b want 0", bus.forced); end
      for (int k = 0; k < 256; k++) begin
         n_cmp++;
         if (w_log[(b + k) & 8191] !== ramp_w(k) || d_log[(b + k) & 8191] !== ramp_d(k)) begin
            n_bad++; errs++;
            if (errs < 5) $display("FAIL ramp_k%0d got w=%0d d=%0d want w=%0d d=%0d", k,
               w_log[(b + k) & 8191], d_log[(b + k) & 8191], ramp_w(k), ramp_d(k));
         end
      end
   endtask

   task automatic test_forced;
      int b, r0, errs;
      bit got;
      b = vcnt; r0 = runs; errs = 0;
      run_frame(1, 1'b0, 6000, got);
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL forced_timeout got %b want 1", got); end
      n_cmp++; if (bus.forced !== 1'b1) begin n_bad++; $display("FAIL forced_flag got %b want 1", bus.forced); end
      n_cmp++; if (vcnt - b !== 256) begin n_bad++; $display("FAIL forced_len got %0d want 256", vcnt - b); end
      n_cmp++; if (runs - r0 !== 1) begin n_bad++; $display("FAIL forced_runs got %0d want 1", runs - r0); end
      for (int k = 0; k < 256; k++) begin
         n_cmp++;
         if (w_log[(b + k) & 8191] !== 8'd50 || d_log[(b + k) & 8191] !== 8'd128) begin
            n_bad++; errs++;
            if (errs < 5) $display("FAIL forced_k%0d got w=%0d d=%0d want w=50 d=128", k,
               w_log[(b + k) & 8191], d_log[(b + k) & 8191]);
         end
      end
      @(posedge clk); #1;
      n_cmp++; if (bus.forced !== 1'b1) begin n_bad++; $display("FAIL forced_hold got %b want 1", bus.forced); end
   endtask

   task automatic test_square;
      int b, errs;
      bit got;
      b = vcnt; errs = 0;
      run_frame(2, 1'b0, 2000, got);
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL square_timeout got %b want 1", got); end
      n_cmp++; if (bus.forced !== 1'b0) begin n_bad++; $display("FAIL square_forced got %b want 0", bus.forced); end
      n_cmp++; if (vcnt - b !== 256) begin n_bad++; $display("FAIL square_len got %0d want 256", vcnt - b); end
      for (int k = 0; k < 256; k++) begin
         n_cmp++;
         if (w_log[(b + k) & 8191] !== sq_w(k) || d_log[(b + k) & 8191] !== sq_d(k)) begin
            n_bad++; errs++;
            if (errs < 5) $display("FAIL square_k%0d got w=%0d d=%0d want w=%0d d=%0d", k,
               w_log[(b + k) & 8191], d_log[(b + k) & 8191], sq_w(k), sq_d(k));
         end
      end
   endtask

   task automatic test_gaps;
      int b, r0, a0, errs;
      bit got;
      b = vcnt; r0 = runs; a0 = addr_err; errs = 0;
      run_frame(3, 1'b0, 3000, got);
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL gaps_timeout got %b want 1", got); end
      n_cmp++; if (vcnt - b !== 256) begin n_bad++; $display("FAIL gaps_len got %0d want 256", vcnt - b); end
      n_cmp++; if (runs - r0 !== 1) begin n_bad++; $display("FAIL gaps_runs got %0d want 1", runs - r0); end
      n_cmp++; if (addr_err - a0 !== 0) begin n_bad++; $display("FAIL gaps_align got %0d want 0", addr_err - a0); end
      for (int k = 0; k < 256; k++) begin
         n_cmp++;
         if (w_log[(b + k) & 8191] !== ramp_w(k) || d_log[(b + k) & 8191] !== ramp_d(k)) begin
            n_bad++; errs++;
            if (errs < 5) $display("FAIL gaps_k%0d got w=%0d d=%0d want w=%0d d=%0d", k,
               w_log[(b + k) & 8191], d_log[(b + k) & 8191], ramp_w(k), ramp_d(k));
         end
      end
   endtask

   task automatic test_reset_mid;
      int v0, d0, b, errs, smp;
      bit hit, got;
      v0 = vcnt; d0 = done_total; errs = 0; smp = 0; hit = 1'b0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         @(posedge clk); #1;
         if (vcnt - v0 >= 100) hit = 1'b1;
         else begin
            bus.start = (i == 0);
            drive_adc(0, i, smp);
         end
      end
      n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL mid_reach got %b want 1", hit); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++; if (bus.wave_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got %b want 0", bus.wave_valid); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b want 0", bus.busy); end
      n_cmp++; if (bus.dwave_in !== 8'd128) begin n_bad++; $display("FAIL mid_dwave got %0d want 128", bus.dwave_in); end
      n_cmp++; if (bus.tmpl_addr !== 8'd0) begin n_bad++; $display("FAIL mid_addr got %0d want 0", bus.tmpl_addr); end
      repeat (300) @(posedge clk);
      #1;
      n_cmp++; if (done_total !== d0) begin n_bad++; $display("FAIL mid_no_done got %0d want %0d", done_total, d0); end
      b = vcnt;
      run_frame(0, 1'b0, 2000, got);
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL mid_rerun got %b want 1", got); end
      n_cmp++; if (vcnt - b !== 256) begin n_bad++; $display("FAIL mid_len got %0d want 256", vcnt - b); end
      for (int k = 0; k < 256; k++) begin
         n_cmp++;
         if (w_log[(b + k) & 8191] !== ramp_w(k) || d_log[(b + k) & 8191] !== ramp_d(k)) begin
            n_bad++; errs++;
            if (errs < 5) $display("FAIL mid_k%0d got w=%0d d=%0d want w=%0d d=%0d", k,
               w_log[(b + k) & 8191], d_log[(b + k) & 8191], ramp_w(k), ramp_d(k));
         end
      end
   endtask

   initial begin
      test_reset;
      test_ramp;
      test_forced;
      test_square;
      test_gaps;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
